// File: rtl/fifo_top_out_pkg.sv
// Shared definitions for the factorial machine FIFO tops: register map,
// flag bit positions and default geometry.
package fifo_top_out_pkg;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    localparam logic [7:0] ADDR_FLAG  = 8'h10;
    localparam logic [7:0] ADDR_DATA  = 8'h11;
    localparam logic [7:0] ADDR_COUNT = 8'h12;
    localparam logic [7:0] ADDR_CTRL  = 8'h13;
    localparam logic [7:0] ADDR_IRQEN = 8'h14;

    // Bit positions inside the 6-bit {full, empty, wr_ack, wr_err, rd_ack, rd_err} vector
    localparam int FLAG_FULL   = 5;
    localparam int FLAG_EMPTY  = 4;
    localparam int FLAG_WR_ACK = 3;
    localparam int FLAG_WR_ERR = 2;
    localparam int FLAG_RD_ACK = 1;
    localparam int FLAG_RD_ERR = 0;
endpackage

// File: rtl/fifo_out_buf.sv
// Synchronous DEPTH x DW result buffer with push/pop/flush and per-cycle
// ack/err strobes; popped data is registered at the pop edge.
module fifo_out_buf
    import fifo_top_out_pkg::*;
#(
    parameter int P_DW    = DW,
    parameter int P_DEPTH = DEPTH,
    parameter int P_AW    = AW,
    parameter int P_CW    = CW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [P_DW-1:0] din,
    output logic [P_DW-1:0] data_out,
    output logic [P_CW-1:0] count,
    output logic            full,
    output logic            empty,
    output logic            wr_ack,
    output logic            wr_err,
    output logic            rd_ack,
    output logic            rd_err
);
    logic [P_DW-1:0] mem [P_DEPTH];
    logic [P_AW-1:0] wr_ptr;
    logic [P_AW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == P_CW'(P_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flush outranks every other event and suppresses all ack/err strobes.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            wr_ack <= do_push;
            wr_err <= push & full;
            rd_ack <= do_pop;
            rd_err <= pop & empty;
            if (do_push) begin
                wr_ptr <= wr_ptr + P_AW'(1);
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + P_AW'(1);
                data_out <= mem[rd_ptr];
            end else if (pop) begin
                data_out <= '0;
            end
            count <= count + P_CW'(do_push) - P_CW'(do_pop);
        end
    end
endmodule

// File: rtl/fifo_top_out.sv
// Bus-slave result FIFO: the factorial core pushes results, the host drains
// them and controls flush/interrupt through the sel/wr/address register bus.
module fifo_top_out
    import fifo_top_out_pkg::*;
#(
    parameter int P_DW    = DW,
    parameter int P_DEPTH = DEPTH,
    parameter int P_AW    = AW,
    parameter int P_CW    = CW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sel,
    input  logic            wr,
    input  logic [7:0]      address,
    input  logic [P_DW-1:0] din,
    output logic [P_DW-1:0] dout,
    input  logic            core_wr,
    input  logic [P_DW-1:0] core_din,
    output logic            core_full,
    output logic [P_CW-1:0] fifo_cnt,
    output logic [5:0]      fifo_flag,
    output logic            irq
);
    // Core handshake: core_wr is a one-cycle push strobe, accepted on any
    // edge where core_full is low; pushes while full are dropped and flagged.
    logic            sel_q;
    logic            wr_q;
    logic [7:0]      addr_q;
    logic [5:0]      flag_q;
    logic [5:0]      live_flags;
    logic            irq_en;
    logic            rd_en;
    logic            flush;
    logic [P_DW-1:0] buf_data;
    logic [P_CW-1:0] count;
    logic            full;
    logic            empty;
    logic            wr_ack;
    logic            wr_err;
    logic            rd_ack;
    logic            rd_err;
    logic            unused_din;

    assign unused_din = ^din[P_DW-1:1];
    assign rd_en      = sel & ~wr & (address == ADDR_DATA);
    assign flush      = sel & wr & (address == ADDR_CTRL) & din[0];

    fifo_out_buf #(
        .P_DW   (P_DW),
        .P_DEPTH(P_DEPTH),
        .P_AW   (P_AW),
        .P_CW   (P_CW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push    (core_wr),
        .pop     (rd_en),
        .flush   (flush),
        .din     (core_din),
        .data_out(buf_data),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .rd_ack  (rd_ack),
        .rd_err  (rd_err)
    );

    always_comb begin
        live_flags              = '0;
        live_flags[FLAG_FULL]   = full;
        live_flags[FLAG_EMPTY]  = empty;
        live_flags[FLAG_WR_ACK] = wr_ack;
        live_flags[FLAG_WR_ERR] = wr_err;
        live_flags[FLAG_RD_ACK] = rd_ack;
        live_flags[FLAG_RD_ERR] = rd_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            flag_q <= '0;
            irq_en <= 1'b0;
        end else begin
            sel_q  <= sel;
            wr_q   <= wr;
            addr_q <= address;
            flag_q <= live_flags;
            if (sel && wr && address == ADDR_IRQEN) begin
                irq_en <= din[0];
            end
        end
    end

    // Read data decodes from the registered address phase.
    always_comb begin
        dout = '0;
        if (sel_q && !wr_q) begin
            case (addr_q)
                ADDR_FLAG:  dout = {{(P_DW-6){1'b0}}, flag_q};
                ADDR_DATA:  dout = buf_data;
                ADDR_COUNT: dout = {{(P_DW-P_CW){1'b0}}, count};
                ADDR_IRQEN: dout = {{(P_DW-1){1'b0}}, irq_en};
                default:    dout = '0;
            endcase
        end
    end

    assign fifo_cnt  = (sel_q && addr_q[3:0] == 4'h1) ? count : '0;
    assign fifo_flag = (sel_q && addr_q[3:0] == 4'h1) ? live_flags : '0;
    assign core_full = full;
    assign irq       = irq_en & ~empty;
endmodule
